mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port memory between the instruction-fetch port (i-port, read-only) and the load/store port (d-port, read/write).
- Sits between `core` and the unified memory model.
- Issues one memory transaction at a time, in order, and routes the response back to the owning port.
- Replaces direct memory wiring so one memory can serve both fetch and data accesses.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits; must be a multiple of 8.
- SW, DW/8, write-strobe width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held with i_addr until i_gnt.
- i_addr  in  AW  fetch address.
- i_gnt  out  1  one-cycle pulse: fetch request accepted.
- i_rvalid  out  1  one-cycle pulse: i_rdata valid.
- i_rdata  out  DW  fetch data.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_wstrb until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_wstrb  in  SW  byte enables for writes.
- d_gnt  out  1  one-cycle pulse: data request accepted.
- d_rvalid  out  1  one-cycle pulse: read data or write ack valid.
- d_rdata  out  DW  read data; 0 for writes.
- mem_req  out  1  request to memory; held until mem_ready.
- mem_we  out  1  write enable.
- mem_addr  out  AW  address.
- mem_wdata  out  DW  write data.
- mem_wstrb  out  SW  byte enables; all-ones for reads.
- mem_ready  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  memory response (read data or write ack).
- mem_rdata  in  DW  memory read data.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs are 0.
  - Owner is cleared and the round-robin pointer is set to "i last".
  - An in-flight transaction is dropped; a mem_rvalid arriving after reset is ignored.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any request is present, the picker chooses the owner.
  - At the edge, the winning request is latched into the mem_* registers.
  - The owner's gnt pulses high for exactly the next cycle, mem_req=1, and the FSM goes to ISSUE.
  - The losing request stays pending; it is not acknowledged.
- ISSUE:
  - mem_* is held stable with mem_req=1.
  - When mem_ready=1 at an edge: mem_req goes to 0 and the FSM goes to WAIT.
  - mem_rvalid in ISSUE is a protocol violation and is ignored.
- WAIT:
  - When mem_rvalid=1 at an edge, mem_rdata is captured into the owner's rdata (d_rdata forced to 0 for writes).
  - The owner's rvalid pulses for one cycle and the FSM goes to IDLE.
  - The non-owner's rdata holds its previous value.
- Minimum latency, with mem_ready and mem_rvalid each returned in the first possible cycle:
  - req seen in cycle 0.
  - gnt and mem_req in cycle 1.
  - WAIT in cycle 2.
  - rvalid in cycle 3.
  - Next gnt no earlier than cycle 4.
- Arbitration (default, no macro): fixed priority, d-port over i-port.
- Requests that drop before gnt are not latched. A requester withdrawing is legal; the bench must not flag it.
- Exactly one transaction is outstanding at any time. Responses map 1:1 to grants, in grant order.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: two-way round-robin.
  - When both ports request in IDLE, the port not granted last wins.
  - The pointer updates on every grant.
  - A single requester always wins.
- Undefined: fixed d-over-i priority; the pointer register is not synthesised.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2);
  - owner enum (OWN_I=1'b0, OWN_D=1'b1);
  - default widths AW/DW.
- Sub-module mem_arb_pick: combinational winner select from i_req, d_req and the last-owner input, plus a `define switch for the round-robin mode.
- The FSM and datapath registers stay in mem_arbiter.

Test Plan:
- Reset: i_req=1, rst pulled low mid-ISSUE → within 0 cycles all outputs 0; after release a stale mem_rvalid produces no rvalid.
- Single fetch: i_req, i_addr=0x100, mem_ready immediate, mem_rvalid next cycle with 0x00500093 → i_gnt in cycle 1, mem_addr=0x100, mem_wstrb=4'hF, i_rvalid with i_rdata=0x00500093 in cycle 3.
- Write: d_req, d_we=1, d_addr=0x204, d_wdata=0xDEADBEEF, d_wstrb=4'b0011, mem_ready delayed 3 cycles → mem_* held stable for 4 cycles, d_rvalid with d_rdata=0.
- Contention, default: i_req and d_req both asserted continuously for 4 transactions → all 4 grants go to d; i_gnt never pulses.
- Contention, MEM_ARB_RR_EN: same stimulus → grants alternate d,i,d,i; each rvalid reaches the matching port.
- Back-to-back with mem_ready=0 for 10 cycles in ISSUE → no second gnt, no rvalid until mem_rvalid; only one transaction outstanding.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory arbiter and its winner picker.
// The optional round-robin mode is selected by defining MEM_ARB_RR_EN.
package mem_arb_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  function automatic owner_t other_port(input owner_t o);
    return (o == OWN_I) ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the fetch and data ports.
// MEM_ARB_RR_EN defined: two-way round-robin; undefined: data port always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_t last,
  output logic   valid,
  output owner_t owner
);

  assign valid = i_req | d_req;

`ifdef MEM_ARB_RR_EN
  // On contention the port that did not win last time gets the slot.
  always_comb begin
    owner = OWN_I;
    if (i_req && d_req) begin
      owner = other_port(last);
    end else if (d_req) begin
      owner = OWN_D;
    end
  end
`else
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    owner = d_req ? OWN_D : OWN_I;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between a fetch port and a load/store port,
// one transaction in flight at a time. MEM_ARB_RR_EN selects round-robin arbitration.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int SW = DW / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [SW-1:0] d_wstrb,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [SW-1:0] mem_wstrb,
  input  logic          mem_ready,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);

  state_t state;
  owner_t owner;
  logic   pick_valid;
  owner_t pick_owner;
  owner_t last_owner;

`ifdef MEM_ARB_RR_EN
  owner_t last_grant;
  assign last_owner = last_grant;
`else
  assign last_owner = OWN_I;
`endif

  mem_arb_pick u_pick (
    .i_req (i_req),
    .d_req (d_req),
    .last  (last_owner),
    .valid (pick_valid),
    .owner (pick_owner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= OWN_I;
      i_gnt     <= 1'b0;
      i_rvalid  <= 1'b0;
      i_rdata   <= '0;
      d_gnt     <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
`ifdef MEM_ARB_RR_EN
      last_grant <= OWN_I;
`endif
    end else begin
      // Grant and response strobes are single-cycle pulses.
      i_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;

      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner   <= pick_owner;
            mem_req <= 1'b1;
            state   <= ISSUE;
`ifdef MEM_ARB_RR_EN
            last_grant <= pick_owner;
`endif
            if (pick_owner == OWN_D) begin
              d_gnt     <= 1'b1;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_we ? d_wdata : '0;
              mem_wstrb <= d_we ? d_wstrb : '1;
            end else begin
              i_gnt     <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= i_addr;
              mem_wdata <= '0;
              mem_wstrb <= '1;
            end
          end
        end

        ISSUE: begin
          // An early mem_rvalid here is a protocol violation and is ignored.
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= WAIT;
          end
        end

        WAIT: begin
          if (mem_rvalid) begin
            state <= IDLE;
            if (owner == OWN_D) begin
              d_rvalid <= 1'b1;
              d_rdata  <= mem_we ? '0 : mem_rdata;
            end else begin
              i_rvalid <= 1'b1;
              i_rdata  <= mem_rdata;
            end
          end
        end

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter against a transaction-level model.
// The arbitration rule in the model follows MEM_ARB_RR_EN like the design.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_gnt, i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [SW-1:0] d_wstrb = '0;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic          mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .SW(SW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // ---------------- memory contents: reference copy and the copy the DUT drives
  logic [31:0] mem_ref [logic [31:0]];
  logic [31:0] mem_dut [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return mem_ref.exists(a) ? mem_ref[a] : init_word(a);
  endfunction

  function automatic logic [31:0] dut_read(input logic [31:0] a);
    return mem_dut.exists(a) ? mem_dut[a] : init_word(a);
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h200 + (32'($urandom_range(0, 15)) << 2);
  endfunction

  // ---------------- transaction-level reference model
  bit          m_has, m_acc, m_own_d, m_we, m_last_d;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_strb;
  bit          e_i_gnt, e_d_gnt, e_i_rv, e_d_rv;
  logic [31:0] e_i_rdata, e_d_rdata;
  int          n_txn = 0;

  task automatic model_reset();
    m_has = 0; m_acc = 0; m_own_d = 0; m_we = 0; m_last_d = 0;
    e_i_gnt = 0; e_d_gnt = 0; e_i_rv = 0; e_d_rv = 0;
    e_i_rdata = '0; e_d_rdata = '0;
  endtask

  task automatic model_step();
    bit pick_d;
    e_i_gnt = 0; e_d_gnt = 0; e_i_rv = 0; e_d_rv = 0;
    if (!m_has) begin
      if (i_req || d_req) begin
`ifdef MEM_ARB_RR_EN
        pick_d = d_req && (!i_req || !m_last_d);
`else
        pick_d = d_req;
`endif
        m_last_d = pick_d; m_has = 1; m_acc = 0; m_own_d = pick_d;
        if (pick_d) begin
          m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
          m_strb = d_we ? d_wstrb : 4'hF;
          e_d_gnt = 1;
        end else begin
          m_we = 0; m_addr = i_addr; m_wdata = '0; m_strb = 4'hF;
          e_i_gnt = 1;
        end
      end
    end else if (!m_acc) begin
      if (mem_ready) begin
        m_acc = 1;
        if (m_we) mem_ref[m_addr] = merge(ref_read(m_addr), m_wdata, m_strb);
      end
    end else if (mem_rvalid) begin
      m_has = 0;
      n_txn++;
      if (m_own_d) begin
        e_d_rv = 1;
        e_d_rdata = m_we ? 32'h0 : ref_read(m_addr);
      end else begin
        e_i_rv = 1;
        e_i_rdata = ref_read(m_addr);
      end
      $display("txn %0d port=%s we=%0d addr=%h rdata=%h last_d=%0d", n_txn,
               m_own_d ? "d" : "i", m_we, m_addr, m_own_d ? e_d_rdata : e_i_rdata, m_last_d);
    end
  endtask

  // ---------------- memory responder (reacts to what the DUT actually drives)
  bit          o_req, o_we;
  logic [31:0] o_addr, o_wdata;
  logic [3:0]  o_strb;
  bit          r_pend, q_seen;
  int          r_cnt, r_delay, q_cnt, q_delay;
  logic [31:0] r_data;
  int          fix_rdy = -1, fix_rv = -1;
  bit          rdy_block = 0, spur_en = 0, auto_req = 0;

  task automatic resp_reset();
    o_req = 0; r_pend = 0; q_seen = 0; r_cnt = 0; q_cnt = 0;
  endtask

  task automatic resp_step();
    if (mem_rvalid && r_pend) r_pend = 0;
    if (o_req && mem_ready) begin
      r_pend = 1; r_cnt = 0; q_seen = 0;
      r_delay = (fix_rv >= 0) ? fix_rv : int'($urandom_range(0, 2));
      if (o_we) begin
        mem_dut[o_addr] = merge(dut_read(o_addr), o_wdata, o_strb);
        r_data = $urandom;
      end else begin
        r_data = dut_read(o_addr);
      end
    end
  endtask

  task automatic resp_drive();
    o_req = mem_req; o_we = mem_we; o_addr = mem_addr; o_wdata = mem_wdata; o_strb = mem_wstrb;
    if (o_req) begin
      if (!q_seen) begin
        q_seen = 1; q_cnt = 0;
        q_delay = (fix_rdy >= 0) ? fix_rdy : int'($urandom_range(0, 3));
      end else begin
        q_cnt++;
      end
      mem_ready = !rdy_block && (q_cnt >= q_delay);
    end else begin
      q_seen = 0;
      mem_ready = ($urandom_range(0, 9) == 0);
    end
    if (r_pend) begin
      mem_rvalid = (r_cnt >= r_delay);
      r_cnt++;
      mem_rdata = mem_rvalid ? r_data : $urandom;
    end else begin
      mem_rvalid = spur_en && o_req && ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;
    end
  endtask

  task automatic req_drive();
    if (!auto_req) return;
    if (e_i_gnt) begin
      i_req = 1'($urandom_range(0, 1));
      i_addr = rand_addr();
    end else if (i_req) begin
      if ($urandom_range(0, 19) == 0) i_req = 0;
    end else if ($urandom_range(0, 2) == 0) begin
      i_req = 1; i_addr = rand_addr();
    end
    if (e_d_gnt || (!d_req && $urandom_range(0, 2) == 0)) begin
      d_req = e_d_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
      d_we = 1'($urandom_range(0, 1));
      d_addr = rand_addr();
      d_wdata = $urandom;
      d_wstrb = 4'($urandom_range(0, 15));
    end else if (d_req && $urandom_range(0, 19) == 0) begin
      d_req = 0;
    end
  endtask

  task automatic compare_all();
    check("i_gnt", 64'(i_gnt), 64'(e_i_gnt));
    check("d_gnt", 64'(d_gnt), 64'(e_d_gnt));
    check("i_rvalid", 64'(i_rvalid), 64'(e_i_rv));
    check("d_rvalid", 64'(d_rvalid), 64'(e_d_rv));
    check("mem_req", 64'(mem_req), 64'(m_has && !m_acc));
    if (m_has && !m_acc) begin
      check("mem_addr", 64'(mem_addr), 64'(m_addr));
      check("mem_we", 64'(mem_we), 64'(m_we));
      check("mem_wstrb", 64'(mem_wstrb), 64'(m_strb));
      if (m_we) check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    end
    check("i_rdata", 64'(i_rdata), 64'(e_i_rdata));
    check("d_rdata", 64'(d_rdata), 64'(e_d_rdata));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    resp_step();
    @(negedge clk);
    compare_all();
    resp_drive();
    req_drive();
  endtask

  initial begin
    int gnt_at, rv_at, stable, n_gnt, n_rv;
    logic [3:0]  seq;
    logic [31:0] iw;

    model_reset();
    resp_reset();
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    compare_all();
    check("rst_mem_addr", 64'(mem_addr), 64'h0);
    check("rst_mem_wstrb", 64'(mem_wstrb), 64'h0);
    rst = 1'b1;
    fix_rdy = 0; fix_rv = 0;
    resp_drive();

    // Single fetch with minimum latency.
    mem_ref[32'h100] = 32'h00500093;
    mem_dut[32'h100] = 32'h00500093;
    i_req = 1; i_addr = 32'h100;
    gnt_at = -1; rv_at = -1;
    for (int c = 1; c <= 8; c++) begin
      cycle();
      if (i_gnt && gnt_at < 0) begin
        gnt_at = c;
        check("fetch_mem_addr", 64'(mem_addr), 64'h100);
        check("fetch_mem_wstrb", 64'(mem_wstrb), 64'hF);
      end
      if (i_rvalid && rv_at < 0) begin
        rv_at = c;
        check("fetch_rdata", 64'(i_rdata), 64'h00500093);
      end
      if (e_i_gnt) i_req = 0;
    end
    check("fetch_gnt_cycle", 64'(gnt_at), 64'd1);
    check("fetch_rv_cycle", 64'(rv_at), 64'd3);

    // Write with mem_ready delayed by three cycles.
    fix_rdy = 3;
    d_req = 1; d_we = 1; d_addr = 32'h204; d_wdata = 32'hDEADBEEF; d_wstrb = 4'b0011;
    stable = 0; rv_at = -1;
    for (int c = 1; c <= 10; c++) begin
      cycle();
      if (mem_req && mem_we && mem_addr == 32'h204 && mem_wdata == 32'hDEADBEEF &&
          mem_wstrb == 4'b0011) stable++;
      if (d_rvalid && rv_at < 0) begin
        rv_at = c;
        check("write_rdata", 64'(d_rdata), 64'h0);
      end
      if (e_d_gnt) d_req = 0;
    end
    check("write_hold_cycles", 64'(stable), 64'd4);
    check("write_rv_cycle", 64'(rv_at), 64'd6);

    // Read back the partially written word.
    fix_rdy = 0;
    d_req = 1; d_we = 0; d_addr = 32'h204;
    iw = init_word(32'h204);
    rv_at = -1;
    for (int c = 1; c <= 8; c++) begin
      cycle();
      if (e_d_gnt) d_req = 0;
      if (d_rvalid && rv_at < 0) begin
        rv_at = c;
        check("readback", 64'(d_rdata), 64'({iw[31:16], 16'hBEEF}));
      end
    end
    check("readback_seen", 64'(rv_at), 64'd3);

    // Asynchronous reset in the middle of an ISSUE phase, then a stale response.
    rdy_block = 1;
    i_req = 1; i_addr = 32'h140;
    repeat (3) cycle();
    #2 rst = 1'b0;
    #1;
    check("arst_strobes", 64'({i_gnt, i_rvalid, d_gnt, d_rvalid, mem_req, mem_we}), 64'h0);
    check("arst_mem_addr", 64'(mem_addr), 64'h0);
    check("arst_mem_wstrb", 64'(mem_wstrb), 64'h0);
    check("arst_i_rdata", 64'(i_rdata), 64'h0);
    check("arst_d_rdata", 64'(d_rdata), 64'h0);
    i_req = 0;
    model_reset();
    resp_reset();
    rdy_block = 0;
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
    cycle();
    check("stale_rvalid", 64'({i_rvalid, d_rvalid}), 64'h0);

    // Continuous contention for four transactions.
    i_req = 1; i_addr = 32'h180; d_req = 1; d_we = 0; d_addr = 32'h208;
    seq = '0; n_gnt = 0;
    for (int c = 0; c < 40 && n_gnt < 4; c++) begin
      cycle();
      if (i_gnt || d_gnt) begin
        seq = {seq[2:0], d_gnt};
        n_gnt++;
      end
    end
    i_req = 0; d_req = 0;
    repeat (6) cycle();
    check("contention_grants", 64'(n_gnt), 64'd4);
`ifdef MEM_ARB_RR_EN
    check("contention_order", 64'(seq), 64'b1010);
`else
    check("contention_order", 64'(seq), 64'b1111);
`endif

    // Memory stalls in ISSUE: exactly one transaction may be outstanding.
    rdy_block = 1;
    i_req = 1; i_addr = 32'h1C0; d_req = 1; d_we = 0; d_addr = 32'h20C;
    n_gnt = 0; n_rv = 0;
    for (int c = 0; c < 12; c++) begin
      cycle();
      n_gnt += int'(i_gnt) + int'(d_gnt);
      n_rv  += int'(i_rvalid) + int'(d_rvalid);
    end
    check("stall_grants", 64'(n_gnt), 64'd1);
    check("stall_rvalids", 64'(n_rv), 64'd0);
    i_req = 0; d_req = 0; rdy_block = 0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      n_rv += int'(i_rvalid) + int'(d_rvalid);
    end
    check("stall_release_rvalids", 64'(n_rv), 64'd1);

    // Randomised traffic with withdrawals, random latencies and stray responses.
    fix_rdy = -1; fix_rv = -1; spur_en = 1; auto_req = 1;
    repeat (3000) cycle();
    auto_req = 0; i_req = 0; d_req = 0;
    repeat (20) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
